pkt_capture_buffer: RTL and testbench

PKT_CAPTURE_BUFFER -- requirements
Module: pkt_capture_buffer

---
 rtl/pkt_capture_buffer_pkg.sv | 21 ++
 rtl/pkt_capture_buffer_if.sv | 32 +++
 rtl/pkt_capture_buffer_ram.sv | 25 ++
 rtl/pkt_capture_buffer.sv | 104 ++++++++++
 tb/tb_pkt_capture_buffer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_capture_buffer_pkg.sv
// Shared constants for the packet capture buffer: word widths, default
// geometry, FSM encoding and the stored-word layout.
package pkt_capture_buffer_pkg;

  localparam int DATA_W     = 64;
  localparam int CTRL_W     = 8;
  localparam int WORD_W     = DATA_W + CTRL_W;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CAPT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // One buffer slot: control byte in the top bits, data word below.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } buf_word_t;

endpackage

// File: rtl/pkt_capture_buffer_if.sv
// Upstream word stream, readout port and packet status of the capture
// buffer. The free-packet strobe is named pkt_release because "release"
// is a reserved word.
interface pkt_capture_buffer_if
  import pkt_capture_buffer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              in_wr;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              in_rdy;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [CTRL_W-1:0] rd_ctrl;
  logic              pkt_valid;
  logic [ADDR_W:0]   pkt_len;
  logic              pkt_ovf;
  logic              pkt_release;
  logic [7:0]        drop_cnt;

  modport master (
    output in_wr, in_ctrl, in_data, rd_addr, pkt_release,
    input  in_rdy, rd_data, rd_ctrl, pkt_valid, pkt_len, pkt_ovf, drop_cnt
  );

  modport slave (
    input  in_wr, in_ctrl, in_data, rd_addr, pkt_release,
    output in_rdy, rd_data, rd_ctrl, pkt_valid, pkt_len, pkt_ovf, drop_cnt
  );
endinterface

// File: rtl/pkt_capture_buffer_ram.sv
// Packet word storage: one write port, one read port with a registered
// output. No reset on the array; stale slots are masked by the caller.
module pkt_buf_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 72
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;

  // Write port plus registered read (read-before-write on a shared edge).
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/pkt_capture_buffer.sv
// Captures one packet (start marker .. end marker) from a 64-bit word
// stream into a small buffer, holds it for software readout until
// released, and counts strobes that arrive while the buffer is held.
module pkt_capture_buffer
  import pkt_capture_buffer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic              clk,
  input logic              rst,
  pkt_capture_buffer_if.slave bus
);
  localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(DEPTH);

  logic [1:0]      r_state;
  logic [ADDR_W:0] r_len;
  logic            r_ovf;
  logic [7:0]      r_drop;
  logic            r_hit;

  logic              w_acc;
  logic              w_mark;
  logic              w_full;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  buf_word_t         w_wword;
  buf_word_t         w_rword;

  assign w_acc  = bus.in_wr && bus.in_rdy;
  assign w_mark = (bus.in_ctrl != '0);
  assign w_full = (r_len == LEN_FULL);

  // Only a start marker in IDLE, or any word in CAPTURE with room left,
  // reaches the buffer; reset cycles never write.
  assign w_we    = rst && w_acc &&
                   (((r_state == ST_IDLE) && w_mark) ||
                    ((r_state == ST_CAPT) && !w_full));
  assign w_waddr = (r_state == ST_IDLE) ? '0 : r_len[ADDR_W-1:0];
  assign w_wword = '{ctrl: bus.in_ctrl, data: bus.in_data};

  pkt_buf_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (WORD_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wword),
    .i_raddr (bus.rd_addr),
    .o_rdata (w_rword)
  );

  // Capture FSM, packet length/overflow tracking and held-buffer drop count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc && w_mark) begin
            r_len   <= (ADDR_W+1)'(1);
            r_state <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          if (w_acc) begin
            if (!w_full)     r_len <= r_len + (ADDR_W+1)'(1);
            else if (!w_mark) r_ovf <= 1'b1;
            if (w_mark)      r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.in_wr && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
          if (bus.pkt_release) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Readout mask, registered alongside the RAM output: slots at or past
  // the current length read as zero, which also hides stale contents.
  always_ff @(posedge clk) begin
    if (!rst) r_hit <= 1'b0;
    else      r_hit <= ({1'b0, bus.rd_addr} < r_len);
  end

  assign bus.rd_data   = r_hit ? w_rword.data : '0;
  assign bus.rd_ctrl   = r_hit ? w_rword.ctrl : '0;
  assign bus.in_rdy    = (r_state != ST_DONE);
  assign bus.pkt_valid = (r_state == ST_DONE);
  assign bus.pkt_len   = r_len;
  assign bus.pkt_ovf   = r_ovf;
  assign bus.drop_cnt  = r_drop;
endmodule

// File: tb/tb_pkt_capture_buffer.sv
// Scoreboard bench for pkt_capture_buffer: a packet-level reference model
// predicts every cycle's outputs into a queue that a negedge monitor drains,
// plus directed constant checks for the documented scenarios.
module tb_pkt_capture_buffer;
  import pkt_capture_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam logic [63:0] S_BAD   = "     bad";
  localparam logic [63:0] S_START = "   start";
  localparam logic [63:0] S_END   = "ork. :'(";

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pkt_capture_buffer_if #(.DEPTH(DEPTH), .ADDR_W(4)) bus ();

  pkt_capture_buffer #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          rdy, vld, ovf;
    int          len, drop;
    logic [7:0]  c;
    logic [63:0] d;
  } exp_t;

  typedef struct {
    logic [7:0]  c;
    logic [63:0] d;
  } word_t;

  exp_t  sbq[$];
  word_t pkt[$];
  bit    m_capt, m_done, m_ovf;
  int    m_drop;
  int    checks = 0;
  int    errors = 0;

  // Packet-level reference: the held packet is just a list of words.
  task automatic model(bit wr, logic [7:0] c, logic [63:0] d, int addr,
                       bit rel, bit rstn);
    exp_t e;
    e.c = '0; e.d = '0;
    if (!rstn) begin
      pkt.delete();
      m_capt = 0; m_done = 0; m_ovf = 0; m_drop = 0;
    end else begin
      if (addr < pkt.size()) begin
        e.c = pkt[addr].c; e.d = pkt[addr].d;
      end
      if (m_done) begin
        if (wr && m_drop < 255) m_drop++;
        if (rel) begin
          m_done = 0; m_ovf = 0; pkt.delete();
        end
      end else if (wr) begin
        if (!m_capt) begin
          if (c != 0) begin
            pkt.push_back('{c: c, d: d});
            m_capt = 1;
          end
        end else begin
          if (pkt.size() < DEPTH) pkt.push_back('{c: c, d: d});
          else if (c == 0)        m_ovf = 1;
          if (c != 0) begin
            m_capt = 0; m_done = 1;
          end
        end
      end
    end
    e.rdy = !m_done; e.vld = m_done; e.ovf = m_ovf;
    e.len = pkt.size(); e.drop = m_drop;
    sbq.push_back(e);
  endtask

  task automatic step(bit wr, logic [7:0] c, logic [63:0] d, int addr,
                      bit rel, bit rstn);
    bus.in_wr = wr; bus.in_ctrl = c; bus.in_data = d;
    bus.rd_addr = 4'(addr); bus.pkt_release = rel; rst = rstn;
    @(posedge clk);
    model(wr, c, d, addr, rel, rstn);
    #1;
  endtask

  task automatic idle(int addr);
    step(0, 8'h00, 64'h0, addr, 0, 1);
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle's outputs are compared with the oldest prediction.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if ({bus.in_rdy, bus.pkt_valid, bus.pkt_ovf, bus.pkt_len, bus.drop_cnt,
           bus.rd_ctrl, bus.rd_data} !==
          {e.rdy, e.vld, e.ovf, 5'(e.len), 8'(e.drop), e.c, e.d}) begin
        errors++;
        $display("FAIL sb t=%0t rdy %b/%b vld %b/%b ovf %b/%b len %0d/%0d drop %0d/%0d ctrl %h/%h data %h/%h",
                 $time, bus.in_rdy, e.rdy, bus.pkt_valid, e.vld, bus.pkt_ovf, e.ovf,
                 bus.pkt_len, e.len, bus.drop_cnt, e.drop, bus.rd_ctrl, e.c,
                 bus.rd_data, e.d);
      end
    end
  end

  initial begin
    bus.in_wr = 0; bus.in_ctrl = 0; bus.in_data = 0;
    bus.rd_addr = 0; bus.pkt_release = 0;

    // Reset, with a strobe that must be ignored.
    step(1, 8'h01, 64'h55, 0, 0, 0);
    step(0, 8'h00, 64'h0, 0, 0, 0);
    chk("rst_rdy", 64'(bus.in_rdy), 64'd1);
    chk("rst_vld", 64'(bus.pkt_valid), 64'd0);
    chk("rst_len", 64'(bus.pkt_len), 64'd0);
    chk("rst_rd", bus.rd_data, 64'd0);
    chk("rst_drop", 64'(bus.drop_cnt), 64'd0);

    // Leading junk, start, 10 data words, end marker.
    step(1, 8'h00, S_BAD, 0, 0, 1);
    step(1, 8'h00, S_BAD, 0, 0, 1);
    step(1, 8'h01, S_START, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 8'h00, 64'hD0 + 64'(i), 0, 0, 1);
    step(1, 8'h01, S_END, 0, 0, 1);
    idle(0);
    chk("p1_vld", 64'(bus.pkt_valid), 64'd1);
    chk("p1_len", 64'(bus.pkt_len), 64'd12);
    chk("p1_rd0", bus.rd_data, S_START);
    chk("p1_rc0", 64'(bus.rd_ctrl), 64'h01);
    idle(11);
    chk("p1_rd11", bus.rd_data, S_END);
    chk("p1_rc11", 64'(bus.rd_ctrl), 64'h01);
    idle(12);
    chk("p1_rd12", bus.rd_data, 64'd0);
    chk("p1_rc12", 64'(bus.rd_ctrl), 64'd0);

    // Strobes while held are counted, not stored; counter saturates.
    for (int i = 0; i < 3; i++) step(1, 8'h01, 64'hBEEF, 5, 0, 1);
    chk("drop3", 64'(bus.drop_cnt), 64'd3);
    chk("drop3_len", 64'(bus.pkt_len), 64'd12);
    chk("drop3_rd5", bus.rd_data, 64'hD4);
    for (int i = 0; i < 297; i++) step(1, 8'h00, 64'hBEEF, 1, 0, 1);
    chk("drop_sat", 64'(bus.drop_cnt), 64'd255);

    // Release frees the packet but keeps the drop count.
    step(0, 8'h00, 64'h0, 0, 1, 1);
    chk("rel_vld", 64'(bus.pkt_valid), 64'd0);
    chk("rel_rdy", 64'(bus.in_rdy), 64'd1);
    chk("rel_len", 64'(bus.pkt_len), 64'd0);
    chk("rel_drop", 64'(bus.drop_cnt), 64'd255);

    // Release during capture has no effect.
    step(1, 8'h02, 64'hA1, 0, 0, 1);
    step(1, 8'h00, 64'hA2, 0, 0, 1);
    step(1, 8'h00, 64'hA3, 0, 1, 1);
    chk("relc_len", 64'(bus.pkt_len), 64'd3);
    chk("relc_vld", 64'(bus.pkt_valid), 64'd0);
    step(1, 8'h04, 64'hA4, 0, 0, 1);
    chk("relc_end", 64'(bus.pkt_len), 64'd4);
    step(0, 8'h00, 64'h0, 0, 1, 1);

    // Overflow: start, 20 data words, end marker.
    step(1, 8'h01, 64'hA000, 0, 0, 1);
    for (int i = 1; i <= 20; i++) step(1, 8'h00, 64'hA000 + 64'(i), 0, 0, 1);
    step(1, 8'h01, 64'hEEEE, 15, 0, 1);
    idle(15);
    chk("ovf_len", 64'(bus.pkt_len), 64'd16);
    chk("ovf_flag", 64'(bus.pkt_ovf), 64'd1);
    chk("ovf_vld", 64'(bus.pkt_valid), 64'd1);
    chk("ovf_rd15", bus.rd_data, 64'hA00F);
    chk("ovf_rc15", 64'(bus.rd_ctrl), 64'd0);
    step(0, 8'h00, 64'h0, 0, 1, 1);
    chk("ovf_clr", 64'(bus.pkt_ovf), 64'd0);

    // Reset mid-capture abandons the packet.
    step(1, 8'h01, 64'hC0, 0, 0, 1);
    for (int i = 1; i < 5; i++) step(1, 8'h00, 64'hC0 + 64'(i), 2, 0, 1);
    step(0, 8'h00, 64'h0, 2, 0, 0);
    chk("mrst_len", 64'(bus.pkt_len), 64'd0);
    chk("mrst_rd", bus.rd_data, 64'd0);
    chk("mrst_rdy", 64'(bus.in_rdy), 64'd1);
    chk("mrst_drop", 64'(bus.drop_cnt), 64'd0);
    idle(2);
    chk("mrst_mask", bus.rd_data, 64'd0);

    // Start immediately followed by end.
    step(1, 8'h11, 64'h5151, 0, 0, 1);
    step(1, 8'h22, 64'h5252, 0, 0, 1);
    idle(0);
    chk("se_len", 64'(bus.pkt_len), 64'd2);
    chk("se_vld", 64'(bus.pkt_valid), 64'd1);
    chk("se_rd0", bus.rd_data, 64'h5151);
    idle(1);
    chk("se_rd1", bus.rd_data, 64'h5252);
    chk("se_rc1", 64'(bus.rd_ctrl), 64'h22);
    step(0, 8'h00, 64'h0, 0, 1, 1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] c;
      c = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      step($urandom_range(0, 3) != 0, c, {$urandom, $urandom},
           $urandom_range(0, 15), $urandom_range(0, 9) == 0,
           $urandom_range(0, 299) != 0);
    end

    // Let the monitor drain, bounded.
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
